// File: rtl/pulse_capture.sv
// pulse_capture: measures the width of each constant-level segment of an async input and reports it over valid/ready
module pulse_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             meas_level,
  output logic [CNT_W-1:0] meas_width,
  output logic             meas_sat,
  output logic             overrun,
  input  logic             clear_overrun
);
  typedef enum logic {IDLE, MEAS} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_q, edg, done, slot_free;
  assign sync_q    = sync[SYNC_STAGES-1];
  assign edg       = sync_q != prev_q;
  assign done      = state == MEAS && edg;
  assign slot_free = !meas_valid || meas_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync       <= '0;
      prev_q     <= 1'b0;
      cnt        <= '0;
      meas_valid <= 1'b0;
      meas_level <= 1'b0;
      meas_width <= '0;
      meas_sat   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q;
      if (edg) begin
        state <= MEAS;
        cnt   <= 1;
      end else if (state == MEAS && cnt != MAX) cnt <= cnt + 1'b1;
      if (done && slot_free) begin
        meas_valid <= 1'b1;
        meas_level <= prev_q;
        meas_width <= cnt;
        meas_sat   <= cnt == MAX;
      end else if (meas_ready) meas_valid <= 1'b0;
      overrun <= (done && !slot_free) || (overrun && !clear_overrun);
    end
  end
endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture: directed, table-driven checks of pulse widths, latency, back-pressure, saturation and reset
module tb_pulse_capture;
  localparam int CW = 8;
  typedef struct {bit l; int n;} seg_t;
  typedef struct {bit l; int w; bit s;} rec_t;
  logic          clk = 0, rst_n = 0, sig_in = 0, meas_ready = 1, clear_overrun = 0;
  logic          meas_valid, meas_level, meas_sat, overrun;
  logic [CW-1:0] meas_width;
  int            total = 0, passed = 0, vrun = 0, vmax = 0;
  rec_t          got[$];

  pulse_capture #(.CNT_W(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .meas_level(meas_level), .meas_width(meas_width), .meas_sat(meas_sat), .overrun(overrun),
    .clear_overrun(clear_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && meas_valid && meas_ready) got.push_back('{meas_level, int'(meas_width), meas_sat});
    vrun = meas_valid ? vrun + 1 : 0;
    if (vrun > vmax) vmax = vrun;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold(input bit v, input int n);
    sig_in = v;
    tick(n);
  endtask

  task automatic cmp_rec(input string name, input int i, input rec_t e);
    if (i < got.size()) begin
      chk({name, ".level"}, int'(got[i].l), int'(e.l));
      chk({name, ".width"}, got[i].w, e.w);
      chk({name, ".sat"}, int'(got[i].s), int'(e.s));
    end else chk({name, ".present"}, 0, 1);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, ".valid"}, int'(meas_valid), 0);
    chk({name, ".level"}, int'(meas_level), 0);
    chk({name, ".width"}, int'(meas_width), 0);
    chk({name, ".sat"}, int'(meas_sat), 0);
    chk({name, ".overrun"}, int'(overrun), 0);
  endtask

  task automatic do_reset(input bit ready);
    rst_n = 0;
    tick(2);
    meas_ready = ready;
    rst_n = 1;
    got.delete();
  endtask

  initial begin
    seg_t segs[6];
    rec_t exp_s[4];
    seg_t sat_segs[4];
    rec_t exp_sat[2];
    segs    = '{'{0, 20}, '{1, 100}, '{0, 10}, '{1, 10}, '{0, 50}, '{1, 10}};
    exp_s   = '{'{1, 100, 0}, '{0, 10, 0}, '{1, 10, 0}, '{0, 50, 0}};
    sat_segs = '{'{0, 5}, '{1, 300}, '{0, 5}, '{1, 5}};
    exp_sat = '{'{1, 255, 1}, '{0, 5, 0}};

    // reset state and basic sanity sequence
    tick(2);
    chk_reset_vals("rst");
    do_reset(1);
    foreach (segs[i]) hold(segs[i].l, segs[i].n);
    chk("sanity.count", got.size(), 4);
    foreach (exp_s[i]) cmp_rec($sformatf("sanity[%0d]", i), i, exp_s[i]);
    chk("sanity.overrun", int'(overrun), 0);

    // latency of a 7-cycle high pulse
    sig_in = 0;
    do_reset(1);
    hold(0, 5);
    hold(1, 7);
    chk("lat.arm_norep", got.size(), 0);
    sig_in = 0;
    tick(2);
    chk("lat.valid_early", int'(meas_valid), 0);
    tick(1);
    chk("lat.valid", int'(meas_valid), 1);
    chk("lat.level", int'(meas_level), 1);
    chk("lat.width", int'(meas_width), 7);
    chk("lat.sat", int'(meas_sat), 0);
    tick(1);
    chk("lat.valid_drop", int'(meas_valid), 0);

    // back-pressure and overrun
    do_reset(0);
    hold(0, 5);
    hold(1, 10);
    hold(0, 10);
    chk("bp.held_valid", int'(meas_valid), 1);
    chk("bp.held_overrun", int'(overrun), 0);
    hold(1, 10);
    chk("bp.mid_width", int'(meas_width), 10);
    chk("bp.mid_overrun", int'(overrun), 1);
    hold(0, 10);
    chk("bp.valid", int'(meas_valid), 1);
    chk("bp.level", int'(meas_level), 1);
    chk("bp.width", int'(meas_width), 10);
    chk("bp.overrun", int'(overrun), 1);
    meas_ready = 1;
    tick(1);
    chk("bp.accept_drop", int'(meas_valid), 0);
    chk("bp.accept_count", got.size(), 1);
    cmp_rec("bp.accepted", 0, '{1, 10, 0});
    chk("bp.overrun_sticky", int'(overrun), 1);
    clear_overrun = 1;
    tick(1);
    clear_overrun = 0;
    chk("bp.overrun_clr", int'(overrun), 0);

    // saturation at 255
    do_reset(1);
    foreach (sat_segs[i]) hold(sat_segs[i].l, sat_segs[i].n);
    chk("sat.count", got.size(), 2);
    foreach (exp_sat[i]) cmp_rec($sformatf("sat[%0d]", i), i, exp_sat[i]);

    // alternating 1-cycle pulses with ready high
    got.delete();
    vmax = 0;
    for (int i = 0; i < 7; i++) hold(i % 2 == 1, 1);
    hold(1, 6);
    chk("alt.count", got.size(), 8);
    cmp_rec("alt[0]", 0, '{1, 5, 0});
    for (int i = 1; i < 8; i++) cmp_rec($sformatf("alt[%0d]", i), i, '{i % 2 == 0, 1, 0});
    chk("alt.valid_run", vmax, 8);
    chk("alt.overrun", int'(overrun), 0);

    // reset while a result is held and overrun is set
    sig_in = 0;
    do_reset(0);
    hold(0, 3);
    hold(1, 5);
    hold(0, 5);
    hold(1, 5);
    chk("mrst.pre_valid", int'(meas_valid), 1);
    chk("mrst.pre_overrun", int'(overrun), 1);
    rst_n = 0;
    tick(1);
    chk_reset_vals("mrst");
    tick(1);
    meas_ready = 1;
    rst_n = 1;
    got.delete();
    hold(1, 10);
    chk("mrst.arm_norep", got.size(), 0);
    chk("mrst.arm_valid", int'(meas_valid), 0);
    hold(0, 5);
    chk("mrst.count", got.size(), 1);
    cmp_rec("mrst.first", 0, '{1, 10, 0});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
